// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and FSM state encoding for the sequential Vedic multiplier
package vedic_pkg;

    // Half-operand width used by the 4x4 partial-product multipliers
    localparam int HALF_W = 4;
    // Full product width
    localparam int PROD_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        ADD1 = 3'd2,
        ADD2 = 3'd3,
        ADD3 = 3'd4,
        DONE = 3'd5
    } state_t;

endpackage

// File: rtl/vedic_mul4.sv
// rtl/vedic_mul4.sv - combinational 4x4 -> 8 Urdhva-Tiryakbhyam multiplier
module vedic_mul4
    import vedic_pkg::*;
(
    input  logic [HALF_W-1:0]   i_a,
    input  logic [HALF_W-1:0]   i_b,
    output logic [2*HALF_W-1:0] o_p
);

    // Column sum (vertical and crosswise terms plus incoming carry) and carry to the next column
    logic [3:0] w_col;
    logic [3:0] w_carry;

    // Walk the seven Urdhva columns, each producing one product bit and a carry into the next
    always_comb begin
        o_p     = '0;
        w_col   = '0;
        w_carry = '0;
        for (int k = 0; k < 2*HALF_W-1; k++) begin
            w_col = w_carry;
            for (int i = 0; i < HALF_W; i++) begin
                if ((k - i) >= 0 && (k - i) < HALF_W) begin
                    w_col = w_col + {3'b000, i_a[i] & i_b[k-i]};
                end
            end
            o_p[k]  = w_col[0];
            w_carry = {1'b0, w_col[3:1]};
        end
        // Final carry out of column 6 is at most 1 because 15*15 < 256
        o_p[2*HALF_W-1] = w_carry[0];
    end

endmodule

// File: rtl/vedic_mul8_seq.sv
// rtl/vedic_mul8_seq.sv - multi-cycle 8x8 Vedic multiplier with shared 8-bit adder; option VEDIC_MUL_ZERO_SKIP_EN
module vedic_mul8_seq
    import vedic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        a,
    input  logic [7:0]        b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product
);

    state_t              r_state;
    logic [7:0]          r_a;
    logic [7:0]          r_b;
    logic [7:0]          r_p0;
    logic [7:0]          r_p1;
    logic [7:0]          r_p2;
    logic [7:0]          r_p3;
    logic [8:0]          r_s1;
    logic [7:0]          r_lo;
    logic                r_c1;
    logic                r_zero;
    logic [PROD_W-1:0]   r_product;
    logic                r_out_valid;

    logic [7:0]          w_p0;
    logic [7:0]          w_p1;
    logic [7:0]          w_p2;
    logic [7:0]          w_p3;
    logic [7:0]          w_add_x;
    logic [7:0]          w_add_y;
    logic                w_add_cin;
    logic [8:0]          w_add_sum;
    logic                w_accept;
    logic                w_zero_op;

    vedic_mul4 u_mul_p0 (.i_a(r_a[3:0]), .i_b(r_b[3:0]), .o_p(w_p0));
    vedic_mul4 u_mul_p1 (.i_a(r_a[7:4]), .i_b(r_b[3:0]), .o_p(w_p1));
    vedic_mul4 u_mul_p2 (.i_a(r_a[3:0]), .i_b(r_b[7:4]), .o_p(w_p2));
    vedic_mul4 u_mul_p3 (.i_a(r_a[7:4]), .i_b(r_b[7:4]), .o_p(w_p3));

    assign w_accept  = in_valid && (r_state == IDLE);

`ifdef VEDIC_MUL_ZERO_SKIP_EN
    assign w_zero_op = (a == 8'h00) || (b == 8'h00);
`else
    assign w_zero_op = 1'b0;
`endif

    // Operand select for the single shared x + y + cin adder, one reduction step per state
    always_comb begin
        w_add_x   = '0;
        w_add_y   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            ADD1: begin
                w_add_x = r_p1;
                w_add_y = r_p2;
            end
            ADD2: begin
                w_add_x = r_p0;
                w_add_y = {r_s1[3:0], 4'b0000};
            end
            ADD3: begin
                w_add_x   = r_p3;
                w_add_y   = {3'b000, r_s1[8:4]};
                w_add_cin = r_c1;
            end
            default: begin
                w_add_x   = '0;
                w_add_y   = '0;
                w_add_cin = 1'b0;
            end
        endcase
    end

    assign w_add_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {8'h00, w_add_cin};

    // Control FSM and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_p0        <= '0;
            r_p1        <= '0;
            r_p2        <= '0;
            r_p3        <= '0;
            r_s1        <= '0;
            r_lo        <= '0;
            r_c1        <= 1'b0;
            r_zero      <= 1'b0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_zero  <= w_zero_op;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    // Zero operands short-circuit here so the result appears one edge after accept
                    if (r_zero) begin
                        r_product   <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_p0    <= w_p0;
                        r_p1    <= w_p1;
                        r_p2    <= w_p2;
                        r_p3    <= w_p3;
                        r_state <= ADD1;
                    end
                end
                ADD1: begin
                    r_s1    <= w_add_sum;
                    r_state <= ADD2;
                end
                ADD2: begin
                    r_lo    <= w_add_sum[7:0];
                    r_c1    <= w_add_sum[8];
                    r_state <= ADD3;
                end
                ADD3: begin
                    r_product   <= {w_add_sum[7:0], r_lo};
                    r_out_valid <= 1'b1;
                    r_state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule

// File: tb/tb_vedic_mul8_seq.sv
// tb/tb_vedic_mul8_seq.sv - self-checking bench for vedic_mul8_seq against a cycle-level behavioural model
module tb_vedic_mul8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en     = 1'b0;
    bit rand_phase = 1'b0;
    int n_acc = 0;
    int n_out = 0;

    int          m_cnt   = 0;
    bit          m_valid = 1'b0;
    logic [15:0] m_prod  = 16'h0000;
    logic [15:0] m_pend  = 16'h0000;

    vedic_mul8_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [7:0] x, input logic [7:0] y);
`ifdef VEDIC_MUL_ZERO_SKIP_EN
        return (x == 8'h00 || y == 8'h00) ? 1 : 4;
`else
        return 4;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare DUT against the model, then advance the model for the upcoming edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cyc_in_ready", 32'(in_ready), 32'(m_cnt == 0 && !m_valid));
            chk("cyc_product", 32'(product), 32'(m_prod));
        end
        if (rand_phase && rst_n && out_valid && out_ready) n_out++;
        if (!rst_n) begin
            m_cnt   = 0;
            m_valid = 1'b0;
            m_prod  = 16'h0000;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_valid = 1'b1;
                m_prod  = m_pend;
            end
        end else if (in_valid) begin
            m_pend = 16'(a) * 16'(b);
            m_cnt  = lat_of(a, b);
            if (rand_phase) n_acc++;
        end
    end

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp,
                          input int exp_lat, input string nm);
        int cyc;
        a         = ta;
        b         = tb_v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            step();
            cyc++;
        end
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({nm, "_product"}, 32'(product), 32'(exp));
        step();
        chk({nm, "_in_ready_after"}, 32'(in_ready), 32'd1);
        chk({nm, "_out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int cyc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        step();
        chk_en = 1'b1;
        step();
        step();
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_product", 32'(product), 32'h0000);
        rst_n = 1'b1;
        step();
        chk("release_in_ready", 32'(in_ready), 32'd1);

        run_op(8'hFF, 8'hFF, 16'hFE01, 4, "max");
        run_op(8'h0F, 8'h10, 16'h00F0, 4, "cross");
        run_op(8'd13, 8'd11, 16'h008F, 4, "cross2");
        run_op(8'h00, 8'h7E, 16'h0000, lat_of(8'h00, 8'h7E), "zero");

        // Backpressure: result must hold for 10 stalled cycles
        a = 8'hA5;
        b = 8'h3C;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            step();
            cyc++;
        end
        chk("bp_latency", 32'(cyc), 32'd4);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_product", 32'(product), 32'h26AC);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);

        // Reset during ADD2 discards the operation
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_product", 32'(product), 32'h0000);
        rst_n = 1'b1;
        step();
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        repeat (6) step();
        chk("midrst_no_stale", 32'(out_valid), 32'd0);

        // Randomized traffic with stalls and occasional zero operands
        rand_phase = 1'b1;
        for (int i = 0; i < 15000; i++) begin
            a         = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            b         = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        rand_phase = 1'b0;
        chk("one_output_per_accept", 32'(n_out), 32'(n_acc));
        chk("enough_accepts", 32'(n_acc > 1000), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
